// File: rtl/vrased_reset_ctrl_if.sv
// Bundle of violation inputs, CPU feedback and the software-visible
// violation record exchanged with the VRASED reset sequencer.
interface vrased_reset_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic [5:0]       viol;
  logic [15:0]      pc;
  logic             cause_clr;
  logic             cpu_rst;
  logic [5:0]       cause;
  logic [CNT_W-1:0] viol_cnt;
  logic             retry;
  logic             busy;

  // Monitor / CPU side: raises violations, reports pc, reads the record
  modport master (
    output viol, pc, cause_clr,
    input  cpu_rst, cause, viol_cnt, retry, busy
  );

  // Sequencer side
  modport slave (
    input  viol, pc, cause_clr,
    output cpu_rst, cause, viol_cnt, retry, busy
  );
endinterface

// File: rtl/vrased_reset_ctrl.sv
// VRASED reset sequencer: stretches any violation into a CPU reset, checks
// that execution restarts at the reset handler, and records what fired.
module vrased_reset_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned WAIT_MAX      = 16,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int unsigned CNT_W         = 8
) (
  input logic               clk,
  input logic               rst,
  vrased_reset_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_PC} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_MAX - 1);

  state_t           state;
  logic [7:0]       hold_cnt;
  logic [7:0]       wait_cnt;
  logic [5:0]       cause_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retry_q;

  logic             any_viol;
  logic [CNT_W-1:0] cnt_inc;

  // Event detection and saturating increment value
  always_comb begin
    any_viol = |bus.viol;
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Sequencer FSM with violation record
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      wait_cnt <= '0;
      cause_q  <= '0;
      cnt_q    <= '0;
      retry_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_viol) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
            // A clear in the same cycle drops the old bits; the new event wins
            cause_q  <= bus.cause_clr ? bus.viol : (cause_q | bus.viol);
            cnt_q    <= cnt_inc;
          end else if (bus.cause_clr) begin
            cause_q <= '0;
            retry_q <= 1'b0;
          end
        end
        HOLD: begin
          if (any_viol) begin
            cause_q  <= cause_q | bus.viol;
            hold_cnt <= HOLD_LOAD;
          end else if (hold_cnt == '0) begin
            state    <= WAIT_PC;
            wait_cnt <= WAIT_LOAD;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        WAIT_PC: begin
          if (any_viol) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
            cause_q  <= cause_q | bus.viol;
            cnt_q    <= cnt_inc;
          end else if (bus.pc == RESET_HANDLER) begin
            state <= IDLE;
          end else if (wait_cnt == '0) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
            retry_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The violation term asserts reset in the very cycle it is raised
  assign bus.cpu_rst  = rst | (state == HOLD) | any_viol;
  assign bus.busy     = (state != IDLE);
  assign bus.cause    = cause_q;
  assign bus.viol_cnt = cnt_q;
  assign bus.retry    = retry_q;

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Scoreboard bench for vrased_reset_ctrl: two instances (CNT_W=8 and
// CNT_W=2) share stimulus; expected per-cycle outputs are queued by the
// stimulus and popped by a monitor on the falling edge.
module tb_vrased_reset_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  viol;
  logic [15:0] pc;
  logic        cause_clr;

  vrased_reset_ctrl_if #(.CNT_W(8)) bus8 ();
  vrased_reset_ctrl_if #(.CNT_W(2)) bus2 ();

  assign bus8.viol      = viol;
  assign bus8.pc        = pc;
  assign bus8.cause_clr = cause_clr;
  assign bus2.viol      = viol;
  assign bus2.pc        = pc;
  assign bus2.cause_clr = cause_clr;

  vrased_reset_ctrl #(
    .HOLD_CYCLES(4), .WAIT_MAX(16), .RESET_HANDLER(16'h0000), .CNT_W(8)
  ) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  vrased_reset_ctrl #(
    .HOLD_CYCLES(4), .WAIT_MAX(16), .RESET_HANDLER(16'h0000), .CNT_W(2)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    int         cyc;
    logic       cr;
    logic [5:0] cs;
    logic [7:0] n8;
    logic [1:0] n2;
    logic       rt;
    logic       bz;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   t0     = 0;
  int   nchecks = 0;
  int   nfail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: compare every queued expectation due in this cycle
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      nchecks = nchecks + 1;
      if (e.cyc < cyc) begin
        nfail = nfail + 1;
        $display("FAIL expired cyc=%0d: expectation not reached, now cyc=%0d", e.cyc, cyc);
      end else if (bus8.cpu_rst !== e.cr || bus2.cpu_rst !== e.cr ||
                   bus8.cause !== e.cs || bus2.cause !== e.cs ||
                   bus8.viol_cnt !== e.n8 || bus2.viol_cnt !== e.n2 ||
                   bus8.retry !== e.rt || bus2.retry !== e.rt ||
                   bus8.busy !== e.bz || bus2.busy !== e.bz) begin
        nfail = nfail + 1;
        $display("FAIL outputs cyc=%0d got cpu_rst=%b/%b cause=%h/%h cnt=%0d/%0d retry=%b/%b busy=%b/%b want cpu_rst=%b cause=%h cnt=%0d/%0d retry=%b busy=%b",
                 cyc, bus8.cpu_rst, bus2.cpu_rst, bus8.cause, bus2.cause,
                 bus8.viol_cnt, bus2.viol_cnt, bus8.retry, bus2.retry,
                 bus8.busy, bus2.busy, e.cr, e.cs, e.n8, e.n2, e.rt, e.bz);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    t0 = cyc;
  endtask

  // Queue expected outputs for relative cycles k0..k1 of the current scenario
  task automatic ex(input int k0, input int k1, input logic cr, input logic [5:0] cs,
                    input logic [7:0] n8, input logic rt, input logic bz);
    exp_t e;
    for (int k = k0; k <= k1; k++) begin
      e.cyc = t0 + k;
      e.cr  = cr;
      e.cs  = cs;
      e.n8  = n8;
      e.n2  = (n8 > 8'd3) ? 2'd3 : n8[1:0];
      e.rt  = rt;
      e.bz  = bz;
      q.push_back(e);
    end
  endtask

  initial begin
    rst       = 1'b1;
    viol      = '0;
    pc        = 16'hE000;
    cause_clr = 1'b0;

    // Reset: cpu_rst follows rst, record cleared
    next(); mark();
    ex(0, 1, 1'b1, 6'h00, 8'd0, 1'b0, 1'b0);
    ex(2, 3, 1'b0, 6'h00, 8'd0, 1'b0, 1'b0);
    next();
    next(); rst = 1'b0;
    next();

    // Single 1-cycle pulse, pc match in the second WAIT_PC cycle
    next(); mark();
    ex(0, 0, 1'b1, 6'h00, 8'd0, 1'b0, 1'b0);
    ex(1, 4, 1'b1, 6'h04, 8'd1, 1'b0, 1'b1);
    ex(5, 6, 1'b0, 6'h04, 8'd1, 1'b0, 1'b1);
    ex(7, 7, 1'b0, 6'h04, 8'd1, 1'b0, 1'b0);
    viol = 6'h04;
    next(); viol = '0;
    repeat (5) next();
    pc = 16'h0000;
    next(); pc = 16'hE000;

    // Violation during HOLD restarts the count; then WAIT_PC timeout
    next(); mark();
    ex(0, 0, 1'b1, 6'h04, 8'd1, 1'b0, 1'b0);
    ex(1, 2, 1'b1, 6'h05, 8'd2, 1'b0, 1'b1);
    ex(3, 6, 1'b1, 6'h25, 8'd2, 1'b0, 1'b1);
    ex(7, 22, 1'b0, 6'h25, 8'd2, 1'b0, 1'b1);
    ex(23, 26, 1'b1, 6'h25, 8'd2, 1'b1, 1'b1);
    ex(27, 27, 1'b0, 6'h25, 8'd2, 1'b1, 1'b1);
    ex(28, 28, 1'b0, 6'h25, 8'd2, 1'b1, 1'b0);
    viol = 6'h01;
    next(); viol = '0;
    next(); viol = 6'h20;
    next(); viol = '0;
    repeat (24) next();
    pc = 16'h0000;
    next(); pc = 16'hE000;

    // Clear alone, then clear with simultaneous violation, clear ignored in HOLD
    next(); mark();
    ex(0, 0, 1'b0, 6'h25, 8'd2, 1'b1, 1'b0);
    ex(1, 1, 1'b1, 6'h00, 8'd2, 1'b0, 1'b0);
    ex(2, 5, 1'b1, 6'h02, 8'd3, 1'b0, 1'b1);
    ex(6, 6, 1'b0, 6'h02, 8'd3, 1'b0, 1'b1);
    ex(7, 7, 1'b0, 6'h02, 8'd3, 1'b0, 1'b0);
    cause_clr = 1'b1;
    next(); viol = 6'h02;
    next(); viol = '0; cause_clr = 1'b0;
    next(); cause_clr = 1'b1;
    next(); cause_clr = 1'b0;
    next(); next();
    pc = 16'h0000;
    next(); pc = 16'hE000;

    // Async reset during HOLD; 2-bit counter already saturated here
    next(); mark();
    ex(0, 0, 1'b1, 6'h02, 8'd3, 1'b0, 1'b0);
    ex(1, 1, 1'b1, 6'h0A, 8'd4, 1'b0, 1'b1);
    ex(2, 3, 1'b1, 6'h00, 8'd0, 1'b0, 1'b0);
    ex(4, 5, 1'b0, 6'h00, 8'd0, 1'b0, 1'b0);
    viol = 6'h08;
    next(); viol = '0;
    next(); rst = 1'b1;
    next();
    next(); rst = 1'b0;
    next();

    // Four separate events, each completed back to IDLE
    for (int i = 1; i <= 4; i++) begin
      next(); mark();
      ex(0, 0, 1'b1, (i == 1) ? 6'h00 : 6'h01, 8'(i - 1), 1'b0, 1'b0);
      ex(1, 4, 1'b1, 6'h01, 8'(i), 1'b0, 1'b1);
      ex(5, 5, 1'b0, 6'h01, 8'(i), 1'b0, 1'b1);
      ex(6, 6, 1'b0, 6'h01, 8'(i), 1'b0, 1'b0);
      viol = 6'h01;
      next(); viol = '0;
      repeat (4) next();
      pc = 16'h0000;
      next(); pc = 16'hE000;
    end

    repeat (3) next();
    nchecks = nchecks + 1;
    if (q.size() != 0) begin
      nfail = nfail + 1;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/vrased_reset_ctrl.md
# vrased_reset_ctrl

Reset sequencer that consumes the six VRASED violation lines and turns them into a clean, stretched CPU reset request plus a software-visible violation record. It sits between the VRASED monitor sub-blocks and the openMSP430 reset input. It holds the CPU in reset for a fixed number of cycles, then confirms that execution restarts at the reset handler. It also latches which property fired and keeps a saturating count of violation events for post-reset attestation logging.

## Interface
- `HOLD_CYCLES`, 4: cycles `cpu_rst` stays registered-high after the triggering cycle (1..255).
- `WAIT_MAX`, 16: cycles allowed after release for `pc` to equal `RESET_HANDLER` (1..255).
- `RESET_HANDLER`, 16'h0000: expected first fetch address after release.
- `CNT_W`, 8: width of `viol_cnt`.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `viol`  in  6  violation requests: [0] X_stack, [1] AC, [2] atomicity, [3] dma_AC, [4] dma_detect, [5] dma_X_stack; level, may be 1-cycle pulses.
- `pc`  in  16  CPU program counter.
- `cause_clr`  in  1  software clear of `cause` (1-cycle pulse).
- `cpu_rst`  out  1  reset request to CPU.
- `cause`  out  6  sticky OR of violation bits since last clear.
- `viol_cnt`  out  CNT_W  saturating count of violation events.
- `retry`  out  1  sticky flag: a WAIT_PC timeout occurred.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, HOLD, WAIT_PC.
- `cpu_rst` = `rst` | (state==HOLD) | (|viol). The combinational term guarantees reset in the same cycle a violation is raised.
- IDLE:
  - If |viol: go to HOLD, load hold counter with HOLD_CYCLES-1, set `cause` |= viol, and increment `viol_cnt`.
  - Else if `cause_clr`: clear `cause` and `retry`.
- HOLD:
  - Any viol bit ORs into `cause`, reloads the hold counter, and does not increment `viol_cnt` (same event).
  - When the counter is 0 and there is no violation: go to WAIT_PC and load the wait counter with WAIT_MAX-1.
- WAIT_PC:
  - If |viol: go to HOLD, OR into `cause`, and increment `viol_cnt` (new event).
  - Else if `pc`==RESET_HANDLER: go to IDLE.
  - Else if the wait counter is 0: go to HOLD, set `retry`, no count increment.
  - Else decrement the wait counter.
- `cause_clr` is ignored outside IDLE. In IDLE, a simultaneous violation wins: `cause` is loaded with the new `viol` (old bits dropped).
- `viol_cnt` saturates at all-ones and never wraps. It is cleared only by `rst`.

## Timing
- Reset values: state IDLE, `cause`=0, `viol_cnt`=0, `retry`=0, `busy`=0, counters 0.
- `cpu_rst`=1 while `rst` is high.
- A 1-cycle violation pulse in cycle N gives `cpu_rst` high in cycles N..N+HOLD_CYCLES, i.e. HOLD_CYCLES+1 cycles total.
- `cause`, `viol_cnt` and `busy` update at the edge ending cycle N.
- A violation during HOLD restarts the count: `cpu_rst` stays high for HOLD_CYCLES cycles after the last violation cycle.
- A `pc` match in the first WAIT_PC cycle returns to IDLE at the next edge.
- A WAIT_PC timeout re-enters HOLD after WAIT_MAX cycles with no match.
- Asynchronous `rst` mid-sequence aborts immediately to the reset values; no partial state survives.

## Test plan
- HOLD_CYCLES=4, `viol`=6'b000100 for 1 cycle at cycle 10, `pc`=0 at cycle 16 -> `cpu_rst` high cycles 10-14; `cause`=6'h04; `viol_cnt`=1; `busy` drops after cycle 16.
- Violation 6'h01 at cycle 10, then 6'h20 at cycle 12 (during HOLD) -> `cpu_rst` high cycles 10-16; `cause`=6'h21; `viol_cnt`=1.
- After release, hold `pc`=16'hE000 with WAIT_MAX=16 -> after 16 WAIT_PC cycles re-enter HOLD; `retry`=1; `cpu_rst` high for 4 cycles; `viol_cnt` unchanged.
- With `cause`=6'h04 in IDLE: `cause_clr` alone -> `cause`=0 and `retry`=0. Then `cause_clr` with `viol`=6'h02 in the same cycle -> `cause`=6'h02.
- CNT_W=2: four separate violation events, each completed back to IDLE -> `viol_cnt` reads 1, 2, 3, 3.
- Assert `rst` during HOLD -> `cpu_rst`=1 while `rst` is high; all state cleared; after `rst` falls with no violation, `cpu_rst`=0 and `busy`=0.
